entry_rx: RTL and testbench
===========================

Name: entry_rx

Overview:
- UART serial receiver for 8N1 frames: idle-high line, one start bit (low), DATA_BITS data bits sent LSB first, one stop bit (high).
- Synchronises the asynchronous serial input to `clk`, checks the start bit at mid-bit, then samples each data bit and the stop bit at mid-bit.
- Presents each received byte with a one-cycle valid strobe on `out`.
- Sits at the chip's serial input pin and feeds byte-level logic downstream.

Parameters:
- CLKS_PER_BIT, default 4: clock cycles per serial bit. Must be even and >= 4.
- DATA_BITS, default 8: data bits per frame. Legal range 5..8.

Ports:
- clk  input  1  system clock; all logic is on the rising edge.
- rst  input  1  synchronous, active-high reset.
- data  input  1  asynchronous serial line; idles high.
- out  output  1  received-byte strobe; high for exactly one cycle per good frame.
- rx_byte  output  DATA_BITS  last good byte received, LSB = first data bit.
- frame_err  output  1  one-cycle pulse when the stop bit is sampled low.
- busy  output  1  high while a frame is in progress (any state except IDLE).

Behaviour:
- Reset (rst high at a rising edge):
  - state = IDLE, bit counter = 0, clock counter = 0.
  - Both synchroniser flops = 1.
  - out = 0, frame_err = 0, busy = 0, rx_byte = 0.
  - Reset asserted mid-frame aborts the frame: no strobe, no error.
- Synchroniser: two flops on `data`. All FSM decisions use the second flop (`rxs`). This adds 2 cycles of input latency.
- FSM states: IDLE, START, DATA, STOP, BREAK.
- IDLE:
  - When rxs == 0, go to START and clear the clock counter.
- START:
  - Count CLKS_PER_BIT/2 cycles, then sample rxs.
  - If rxs == 0, go to DATA; clear the clock counter and the bit index.
  - If rxs == 1, treat it as a glitch: return to IDLE with no output activity.
- DATA:
  - Every CLKS_PER_BIT cycles, sample rxs into shift register position [bit index]; LSB is sampled first.
  - After the DATA_BITS-th sample, go to STOP.
- STOP:
  - After CLKS_PER_BIT cycles, sample rxs.
  - If rxs == 1: load rx_byte from the shift register and pulse out = 1 for the next cycle. Go to IDLE.
  - If rxs == 0: pulse frame_err for one cycle. rx_byte is unchanged and out stays 0. Go to BREAK.
- BREAK:
  - Wait until rxs == 1, then go to IDLE. This prevents a held-low line from producing repeated frames.
- Timing:
  - Stop-bit sample occurs CLKS_PER_BIT/2 + (DATA_BITS+1)*CLKS_PER_BIT cycles after entering START.
  - out (or frame_err) is registered: high in the cycle immediately after the stop sample.
- Back-to-back frames:
  - A start bit arriving right after the stop bit is accepted.
  - The FSM is back in IDLE one cycle after the stop sample, so no extra idle time is needed.
- rx_byte holds its value until the next good frame; it is never cleared except by reset.
- out and frame_err are never high in the same cycle.
- busy = 1 in START, DATA, STOP and BREAK.

Test Plan:
1. Reset, line held high for 50 cycles -> out = 0, frame_err = 0, busy = 0, rx_byte = 0x00 throughout.
2. CLKS_PER_BIT = 4: send frame 0xA5 (start 0; bits 1,0,1,0,0,1,0,1; stop 1) -> exactly one out pulse 1 cycle wide; rx_byte = 0xA5; frame_err = 0.
3. Send 0x00 then 0xFF back-to-back with no idle gap -> two out pulses; rx_byte = 0x00 after the first and 0xFF after the second.
4. Drive data low for 1 cycle only (shorter than CLKS_PER_BIT/2) -> start glitch rejected; FSM returns to IDLE; no out, no frame_err.
5. Send 0x3C with the stop bit forced low, then hold the line low for 20 cycles -> frame_err pulses once; rx_byte keeps its previous value; no new frame until the line returns high.
6. Assert rst midway through the data bits of 0x55 -> busy = 0 the next cycle; no out pulse; rx_byte = 0x00; a following clean frame 0x55 is received correctly.

Source files
------------

// File: rtl/entry_rx.sv
// UART 8N1 receiver: two-flop input synchroniser, mid-bit sampling FSM,
// one-cycle byte strobe and framing-error pulse.
module entry_rx #(
    parameter int CLKS_PER_BIT = 4,
    parameter int DATA_BITS    = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 data,
    output logic                 out,
    output logic [DATA_BITS-1:0] rx_byte,
    output logic                 frame_err,
    output logic                 busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BW = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_BREAK
    } state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, rxs_q;
    logic [CW-1:0]          clk_cnt_q, clk_cnt_d;
    logic [BW-1:0]          bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]   shift_q;
    logic [DATA_BITS-1:0]   rx_byte_q;
    logic                   out_q, out_d;
    logic                   frame_err_q, frame_err_d;
    logic                   sample_bit;
    logic                   load_byte;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q     <= 1'b1;
            rxs_q       <= 1'b1;
            state_q     <= S_IDLE;
            clk_cnt_q   <= '0;
            bit_idx_q   <= '0;
            rx_byte_q   <= '0;
            out_q       <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sync1_q     <= data;
            rxs_q       <= sync1_q;
            state_q     <= state_d;
            clk_cnt_q   <= clk_cnt_d;
            bit_idx_q   <= bit_idx_d;
            out_q       <= out_d;
            frame_err_q <= frame_err_d;
            if (load_byte) begin
                rx_byte_q <= shift_q;
            end
        end
    end

    // Each shift-register bit captures the line only on its own data-bit sample.
    for (genvar gi = 0; gi < DATA_BITS; gi++) begin : g_shift
        always_ff @(posedge clk) begin
            if (rst) begin
                shift_q[gi] <= 1'b0;
            end else if (sample_bit && (bit_idx_q == BW'(gi))) begin
                shift_q[gi] <= rxs_q;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        clk_cnt_d   = clk_cnt_q + CW'(1);
        bit_idx_d   = bit_idx_q;
        out_d       = 1'b0;
        frame_err_d = 1'b0;
        sample_bit  = 1'b0;
        load_byte   = 1'b0;
        case (state_q)
            S_IDLE: begin
                clk_cnt_d = '0;
                if (!rxs_q) begin
                    state_d = S_START;
                end
            end
            S_START: begin
                if (clk_cnt_q == HALF_LAST) begin
                    clk_cnt_d = '0;
                    bit_idx_d = '0;
                    state_d   = rxs_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (clk_cnt_q == FULL_LAST) begin
                    clk_cnt_d  = '0;
                    sample_bit = 1'b1;
                    if (bit_idx_q == BIT_LAST) begin
                        state_d = S_STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + BW'(1);
                    end
                end
            end
            S_STOP: begin
                if (clk_cnt_q == FULL_LAST) begin
                    clk_cnt_d = '0;
                    if (rxs_q) begin
                        load_byte = 1'b1;
                        out_d     = 1'b1;
                        state_d   = S_IDLE;
                    end else begin
                        frame_err_d = 1'b1;
                        state_d     = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // A held-low line must return high before another start is accepted.
                clk_cnt_d = '0;
                if (rxs_q) begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d   = S_IDLE;
                clk_cnt_d = '0;
            end
        endcase
    end

    assign out       = out_q;
    assign frame_err = frame_err_q;
    assign rx_byte   = rx_byte_q;
    assign busy      = (state_q != S_IDLE);

endmodule

// File: tb/tb_entry_rx.sv
// Self-checking bench for entry_rx: table of frames plus hand-written glitch,
// framing-error and mid-frame reset sequences, checked through a scoreboard.
module tb_entry_rx;

    localparam int CPB = 4;
    localparam int DB  = 8;
    // data low at a falling edge -> 2 sync cycles + 1 detect cycle -> START,
    // then stop sample CPB/2 + (DB+1)*CPB later; pulse visible at next falling edge.
    localparam int LAT = 3 + CPB / 2 + (DB + 1) * CPB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          data = 1'b1;
    logic          out;
    logic [DB-1:0] rx_byte;
    logic          frame_err;
    logic          busy;

    entry_rx #(.CLKS_PER_BIT(CPB), .DATA_BITS(DB)) dut (
        .clk       (clk),
        .rst       (rst),
        .data      (data),
        .out       (out),
        .rx_byte   (rx_byte),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic          is_err;
        logic [DB-1:0] byte_val;
        int            cycle;
    } exp_t;

    typedef struct {
        logic [DB-1:0] byte_val;
        logic          stop_bit;
        int            hold_low;
        int            idle_after;
    } vec_t;

    exp_t          exp_q[$];
    vec_t          vecs[7];
    int            cyc = 0;
    int            checks = 0;
    int            failures = 0;
    logic [DB-1:0] last_good = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
        end
    endtask

    // Scoreboard side: every strobe or error pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (out === 1'b1 && frame_err === 1'b1) begin
            checks++;
            failures++;
            $display("FAIL out_and_err: both high at cycle %0d", cyc);
        end else if (out === 1'b1 || frame_err === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_pulse: out=%0b err=%0b with nothing expected at cycle %0d",
                         out, frame_err, cyc);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("pulse_kind_err", {31'd0, frame_err}, {31'd0, e.is_err});
                check("pulse_cycle", cyc, e.cycle);
                check("rx_byte", {24'd0, rx_byte}, {24'd0, e.byte_val});
                $display("txn: %s rx_byte=%02h expected %02h at cycle %0d",
                         frame_err ? "frame_err" : "byte", rx_byte, e.byte_val, cyc);
            end
        end
    end

    task automatic idle(input int n);
        data = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [DB-1:0] b, input logic stop);
        exp_t e;
        e.cycle = cyc + LAT;
        if (stop) begin
            e.is_err   = 1'b0;
            e.byte_val = b;
            last_good  = b;
        end else begin
            e.is_err   = 1'b1;
            e.byte_val = last_good;
        end
        exp_q.push_back(e);
        data = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < DB; i++) begin
            data = b[i];
            repeat (CPB) @(negedge clk);
        end
        data = stop;
        repeat (CPB) @(negedge clk);
    endtask

    initial begin
        vecs[0] = '{8'hA5, 1'b1, 0, 6};
        vecs[1] = '{8'h00, 1'b1, 0, 0};
        vecs[2] = '{8'hFF, 1'b1, 0, 6};
        vecs[3] = '{8'h3C, 1'b0, 20, 8};
        vecs[4] = '{8'h81, 1'b1, 0, 3};
        vecs[5] = '{8'h5A, 1'b1, 0, 0};
        vecs[6] = '{8'hC3, 1'b1, 0, 6};

        rst  = 1'b1;
        data = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Idle line after reset: everything quiet.
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            check("idle_quiet", {out, frame_err, busy, rx_byte}, 32'd0);
        end

        // Table of frames; a low stop bit is followed by a held-low break.
        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].byte_val, vecs[v].stop_bit);
            if (!vecs[v].stop_bit) begin
                data = 1'b0;
                repeat (vecs[v].hold_low) @(negedge clk);
                check("break_busy", {31'd0, busy}, 32'd1);
            end
            idle(vecs[v].idle_after);
            if (!vecs[v].stop_bit) begin
                check("break_exit_idle", {31'd0, busy}, 32'd0);
            end
        end
        idle(6);

        // One-cycle start glitch: START entered briefly, then rejected.
        data = 1'b0;
        @(negedge clk);
        data = 1'b1;
        repeat (2) @(negedge clk);
        check("glitch_start_busy", {31'd0, busy}, 32'd1);
        repeat (3) @(negedge clk);
        check("glitch_back_idle", {31'd0, busy}, 32'd0);
        check("glitch_rx_byte", {24'd0, rx_byte}, {24'd0, last_good});
        idle(10);

        // Reset in the middle of the data bits of 0x55.
        data = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 4; i++) begin
            data = i[0] ? 1'b0 : 1'b1;
            repeat (CPB) @(negedge clk);
        end
        check("midframe_busy", {31'd0, busy}, 32'd1);
        rst  = 1'b1;
        data = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        last_good = '0;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_out", {31'd0, out}, 32'd0);
        check("rst_rx_byte", {24'd0, rx_byte}, 32'd0);
        idle(10);
        send_frame(8'h55, 1'b1);
        idle(10);

        check("queue_drained", exp_q.size(), 32'd0);
        check("final_rx_byte", {24'd0, rx_byte}, 32'h55);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
